// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the arbitrating mux slice.
package mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;
  localparam int MAX_CH     = 16;

  // Ceiling log2. Result is never below 1, so index ports always have at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for the arbitrating mux: N producer channels in, one consumer out.
interface rr_arb_mux_if
  import mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4
);
  localparam int SEL_W = clog2(NUM_CH);

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;

  // Producer/consumer side driving the mux.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // The mux itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_arb_mux_arbiter.sv
// Combinational one-hot arbiter. Requests are rotated so the pointer channel
// sits at bit 0, the lowest set bit is isolated, and the grant is rotated back.
// Both rotations use a doubled vector so the wrap needs no modulo logic.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int MODE   = MODE_RR,
  localparam int SEL_W = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant
);

  logic [SEL_W-1:0]  ptr_eff;
  logic [NUM_CH-1:0] rot;
  logic [NUM_CH-1:0] rot_gnt;

  // Fixed priority is just round-robin with the pointer pinned at channel 0.
  always_comb begin
    ptr_eff = (MODE == MODE_FIXED) ? '0 : ptr;
    rot     = NUM_CH'({req, req} >> ptr_eff);
    rot_gnt = rot & (~rot + 1'b1);
    grant   = NUM_CH'(({rot_gnt, rot_gnt} << ptr_eff) >> NUM_CH);
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating mux with a single registered, full-throughput output stage.
module rr_arb_mux
  import mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int MODE   = MODE_RR
) (
  input logic        clk,
  input logic        reset,
  rr_arb_mux_if.slave bus
);

  localparam int SEL_W = clog2(NUM_CH);

  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  ptr_nxt;
  logic [SEL_W-1:0]  win;
  logic [WIDTH-1:0]  win_data;
  logic              load;
  logic              any_req;

  logic              ovld;
  logic [WIDTH-1:0]  odata;
  logic [SEL_W-1:0]  osel;

  rr_arbiter #(.NUM_CH(NUM_CH), .MODE(MODE)) u_arb (
    .req   (bus.in_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // The register can take a new beat when empty or being drained this cycle.
  assign load    = !ovld || bus.out_ready;
  assign any_req = |bus.in_valid;

  // Nothing is accepted while reset is held, even though the empty stage would allow it.
  assign bus.in_ready = (load && reset) ? grant : '0;

  assign bus.out_valid = ovld;
  assign bus.out_data  = odata;
  assign bus.out_sel   = osel;

  // One-hot to index encode and AND-OR data select of the winner.
  always_comb begin
    win      = '0;
    win_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) win = win | SEL_W'(i);
      win_data = win_data | ({WIDTH{grant[i]}} & bus.in_data[i*WIDTH +: WIDTH]);
    end
    ptr_nxt = (win == SEL_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
  end

  // Output stage: fill on load with a request, empty on load without one, hold on stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovld  <= 1'b0;
      odata <= '0;
      osel  <= '0;
    end else if (load) begin
      ovld <= any_req;
      if (any_req) begin
        odata <= win_data;
        osel  <= win;
      end
    end
  end

  // Round-robin pointer moves past the winner only on an actual transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (MODE == MODE_RR && load && any_req) begin
      ptr <= ptr_nxt;
    end
  end

endmodule
